// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step scheduler for the adding CPU.
// Turns host commands (single step, run N instructions, run to a PC breakpoint)
// into cpu_step pulses and a cpu_en level. It watches cpu_idle and cpu_pc,
// counts retired instructions and reports why each command stopped.
//
// Ports:
//   clk_in, reset              clock (rising edge) and synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake; ready only while IDLE
//   cmd_op                     00 STEP, 01 RUN_N, 10 RUN_BP, 11 reserved
//   cmd_count, bp_addr         RUN_N count / RUN_BP breakpoint, latched at accept
//   halt_req                   stop after the instruction in flight (sticky)
//   cpu_idle, cpu_pc           CPU status inputs
//   cpu_step, cpu_en           CPU control outputs
//   busy, done, halt_reason    status; halt_reason valid from done to next accept
//   exec_count                 instructions retired since reset
module cpu_run_ctrl #(
  parameter int unsigned PC_W   = 6,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned EXEC_W = 16,
  parameter int unsigned TMO    = 16
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic              halt_req,
  input  logic              cpu_idle,
  input  logic [PC_W-1:0]   cpu_pc,
  output logic              cpu_step,
  output logic              cpu_en,
  output logic              busy,
  output logic              done,
  output logic [1:0]        halt_reason,
  output logic [EXEC_W-1:0] exec_count
);

  localparam int unsigned TW = $clog2(TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    CHECK
  } state_e;

  typedef enum logic [1:0] {
    OP_STEP   = 2'b00,
    OP_RUN_N  = 2'b01,
    OP_RUN_BP = 2'b10,
    OP_RSV    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    R_COUNT   = 2'b00,
    R_BP      = 2'b01,
    R_ABORT   = 2'b10,
    R_TIMEOUT = 2'b11
  } reason_e;

  state_e             state_q, state_d;
  op_e                op_q;
  reason_e            reason_q, reason_d;
  logic [CNT_W-1:0]   rem_q;
  logic [PC_W-1:0]    bp_q;
  logic [TW-1:0]      timer_q;
  logic               halt_q;
  logic [EXEC_W-1:0]  exec_q;
  logic               done_q, done_d;
  logic               en_q;

  logic accept, retire, fault, timer_clr, timer_inc;

  // Next-state and event decode
  always_comb begin
    state_d   = state_q;
    reason_d  = reason_q;
    done_d    = 1'b0;
    accept    = 1'b0;
    retire    = 1'b0;
    fault     = 1'b0;
    timer_clr = 1'b0;
    timer_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          // Zero-length work finishes without touching the CPU
          if (cmd_op == OP_RSV || (cmd_op == OP_RUN_N && cmd_count == '0)) begin
            done_d   = 1'b1;
            reason_d = R_COUNT;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (cpu_idle) begin
          timer_clr = 1'b1;
          state_d   = WAIT_BUSY;
        end else if (timer_q == TMO_LAST) begin
          fault = 1'b1;
        end else begin
          timer_inc = 1'b1;
        end
      end
      WAIT_BUSY: begin
        if (!cpu_idle) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TMO_LAST) begin
          fault = 1'b1;
        end else begin
          timer_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (cpu_idle) begin
          retire  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (op_q == OP_RUN_BP && cpu_pc == bp_q) begin
          done_d   = 1'b1;
          reason_d = R_BP;
          state_d  = IDLE;
        end else if (op_q != OP_RUN_BP && rem_q == '0) begin
          done_d   = 1'b1;
          reason_d = R_COUNT;
          state_d  = IDLE;
        end else if (halt_q) begin
          done_d   = 1'b1;
          reason_d = R_ABORT;
          state_d  = IDLE;
        end else begin
          timer_clr = 1'b1;
          state_d   = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fault) begin
      done_d   = 1'b1;
      reason_d = R_TIMEOUT;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_STEP;
      reason_q <= R_COUNT;
      rem_q    <= '0;
      bp_q     <= '0;
      timer_q  <= '0;
      halt_q   <= 1'b0;
      exec_q   <= '0;
      done_q   <= 1'b0;
      en_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      reason_q <= reason_d;
      done_q   <= done_d;
      if (accept) begin
        op_q    <= op_e'(cmd_op);
        rem_q   <= (cmd_op == OP_STEP) ? CNT_W'(1) : cmd_count;
        bp_q    <= bp_addr;
        halt_q  <= 1'b0;
        timer_q <= '0;
        en_q    <= 1'b1;
      end else begin
        if (state_q != IDLE) halt_q <= halt_q | halt_req;
        if (timer_clr)      timer_q <= '0;
        else if (timer_inc) timer_q <= timer_q + TW'(1);
      end
      if (fault) en_q <= 1'b0;
      if (retire) begin
        exec_q <= exec_q + EXEC_W'(1);
        if (op_q != OP_RUN_BP) rem_q <= rem_q - CNT_W'(1);
      end
    end
  end

  // Step is gated by the live idle flag so it can only ever last the single ISSUE cycle
  assign cpu_step    = (state_q == ISSUE) && cpu_idle;
  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign cpu_en      = en_q;
  assign done        = done_q;
  assign halt_reason = reason_q;
  assign exec_count  = exec_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed self-checking bench for cpu_run_ctrl with a small
// behavioural CPU model (drops idle 2 cycles after a step, raises it 3 cycles
// later and advances its PC by one).
module tb_cpu_run_ctrl;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_count = '0;
  logic [5:0]  bp_addr = '0;
  logic        halt_req = 1'b0;
  logic        cpu_idle = 1'b1;
  logic [5:0]  cpu_pc = '0;
  logic        cpu_step;
  logic        cpu_en;
  logic        busy;
  logic        done;
  logic [1:0]  halt_reason;
  logic [15:0] exec_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  cpu_run_ctrl #(.PC_W(6), .CNT_W(8), .EXEC_W(16), .TMO(16)) dut (
    .clk_in(clk_in), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .bp_addr(bp_addr), .halt_req(halt_req),
    .cpu_idle(cpu_idle), .cpu_pc(cpu_pc), .cpu_step(cpu_step), .cpu_en(cpu_en),
    .busy(busy), .done(done), .halt_reason(halt_reason), .exec_count(exec_count)
  );

  always #5 clk_in = ~clk_in;

  // CPU model
  logic [2:0] m_t = '0;
  logic       stuck = 1'b0;
  logic       pc_load = 1'b0;
  logic [5:0] pc_val = '0;
  always @(posedge clk_in) begin
    if (pc_load)          cpu_pc <= pc_val;
    else if (m_t == 3'd4) cpu_pc <= cpu_pc + 6'd1;
    if (m_t != 3'd0) begin
      m_t <= (m_t == 3'd4) ? 3'd0 : m_t + 3'd1;
      if (m_t == 3'd1) cpu_idle <= 1'b0;
      if (m_t == 3'd4) cpu_idle <= 1'b1;
    end else if (cpu_step && !stuck) begin
      m_t <= 3'd1;
    end
  end

  // Pulse monitor: counts steps/dones and flags illegal step pulses
  int unsigned step_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned viol = 0;
  logic        prev_step = 1'b0;
  always @(negedge clk_in) begin
    if (cpu_step) begin
      step_cnt++;
      if (!cpu_idle) viol++;
      if (prev_step) viol++;
    end
    if (done) done_cnt++;
    prev_step = cpu_step;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] cnt, input logic [5:0] bp);
    tick();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    bp_addr   = bp;
    @(posedge clk_in);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int unsigned limit, output int unsigned cyc, output logic ok);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < limit) begin
      tick();
      cyc++;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic set_pc(input logic [5:0] v);
    tick();
    pc_val  = v;
    pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
  endtask

  initial begin
    int unsigned cyc, s0, d0, exp_exec, k;
    logic ok;

    // Reset values
    repeat (3) tick();
    @(posedge clk_in);
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_step", cpu_step, 0);
    chk("rst_en", cpu_en, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_reason", halt_reason, 0);
    chk("rst_exec", exec_count, 0);
    reset = 1'b0;
    exp_exec = 0;

    // Single STEP: step in the cycle after accept
    s0 = step_cnt;
    issue(2'b00, 8'd0, 6'd0);
    tick();
    chk("step_latency", cpu_step, 1);
    wait_done(100, cyc, ok);
    chk("step_done_seen", ok, 1);
    chk("step_ready_in_done", cmd_ready, 1);
    chk("step_reason", halt_reason, 0);
    exp_exec = 1;
    chk("step_exec", exec_count, exp_exec);
    chk("step_pulses", step_cnt - s0, 1);
    tick();
    chk("done_one_cycle", done, 0);

    // RUN_N 5 from PC 0
    set_pc(6'h00);
    s0 = step_cnt;
    issue(2'b01, 8'd5, 6'd0);
    wait_done(300, cyc, ok);
    chk("run5_done_seen", ok, 1);
    chk("run5_reason", halt_reason, 0);
    exp_exec += 5;
    chk("run5_exec", exec_count, exp_exec);
    chk("run5_pulses", step_cnt - s0, 5);
    chk("run5_pc", cpu_pc, 6'h05);

    // RUN_N 0: done next cycle, no step
    s0 = step_cnt;
    issue(2'b01, 8'd0, 6'd0);
    tick();
    chk("run0_done", done, 1);
    chk("run0_reason", halt_reason, 0);
    chk("run0_busy", busy, 0);
    chk("run0_pulses", step_cnt - s0, 0);

    // Reserved op behaves like an empty command
    issue(2'b11, 8'd7, 6'd0);
    tick();
    chk("rsv_done", done, 1);
    chk("rsv_reason", halt_reason, 0);
    chk("rsv_exec", exec_count, exp_exec);

    // RUN_BP 0x03 from PC 0
    set_pc(6'h00);
    s0 = step_cnt;
    issue(2'b10, 8'd0, 6'h03);
    wait_done(300, cyc, ok);
    chk("bp_done_seen", ok, 1);
    chk("bp_reason", halt_reason, 1);
    chk("bp_pc", cpu_pc, 6'h03);
    exp_exec += 3;
    chk("bp_exec", exec_count, exp_exec);
    chk("bp_pulses", step_cnt - s0, 3);

    // RUN_BP from PC already at bp: must keep running until halted
    s0 = step_cnt;
    d0 = done_cnt;
    issue(2'b10, 8'd0, 6'h03);
    repeat (40) tick();
    chk("bp_again_busy", busy, 1);
    chk("bp_again_no_done", done_cnt - d0, 0);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    wait_done(100, cyc, ok);
    chk("bp_again_done_seen", ok, 1);
    chk("bp_again_reason", halt_reason, 2);
    k = step_cnt - s0;
    chk("bp_again_ran", (k >= 2) ? 1 : 0, 1);
    exp_exec += k;
    chk("bp_again_exec", exec_count, exp_exec);

    // RUN_N 200 with halt during the 2nd instruction
    s0 = step_cnt;
    issue(2'b01, 8'd200, 6'd0);
    cyc = 0;
    while (step_cnt - s0 < 2 && cyc < 100) begin tick(); cyc++; end
    while (cpu_idle && cyc < 100) begin tick(); cyc++; end
    chk("halt_setup", (cyc < 100) ? 1 : 0, 1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    wait_done(100, cyc, ok);
    chk("halt_done_seen", ok, 1);
    chk("halt_reason", halt_reason, 2);
    exp_exec += 2;
    chk("halt_exec", exec_count, exp_exec);
    repeat (5) tick();
    chk("halt_pulses", step_cnt - s0, 2);

    // Timeout: CPU never leaves idle after the step
    stuck = 1'b1;
    s0 = step_cnt;
    issue(2'b00, 8'd0, 6'd0);
    wait_done(60, cyc, ok);
    chk("tmo_done_seen", ok, 1);
    chk("tmo_latency", (cyc >= 17 && cyc <= 19) ? 1 : 0, 1);
    chk("tmo_reason", halt_reason, 3);
    chk("tmo_en", cpu_en, 0);
    chk("tmo_exec", exec_count, exp_exec);
    chk("tmo_pulses", step_cnt - s0, 1);
    stuck = 1'b0;
    // halt_req in IDLE is ignored
    halt_req = 1'b1;
    repeat (3) tick();
    halt_req = 1'b0;
    chk("tmo_en_held", cpu_en, 0);
    issue(2'b00, 8'd0, 6'd0);
    tick();
    chk("en_restored", cpu_en, 1);
    wait_done(100, cyc, ok);
    chk("post_tmo_done_seen", ok, 1);
    chk("post_tmo_reason", halt_reason, 0);
    exp_exec += 1;
    chk("post_tmo_exec", exec_count, exp_exec);

    // Reset during WAIT_DONE of RUN_N
    issue(2'b01, 8'd5, 6'd0);
    cyc = 0;
    while (cpu_idle && cyc < 50) begin tick(); cyc++; end
    tick();
    chk("rstmid_setup", busy, 1);
    reset = 1'b1;
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_step", cpu_step, 0);
    chk("rstmid_exec", exec_count, 0);
    chk("rstmid_ready", cmd_ready, 1);
    d0 = done_cnt;
    repeat (10) tick();
    chk("rstmid_no_done", done_cnt - d0, 0);
    chk("rstmid_idle_stays", busy, 0);

    chk("step_rules", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/step scheduler for the adding CPU. It replaces hand-driven step pulses with a command interface: single step, run N instructions, or run to a PC breakpoint.
- Generates the CPU's step and en inputs and watches its idle and PC outputs. It counts retired instructions and reports why execution halted.
- Sits between the host/debug logic and the CPU core, on the same clock.

Parameters:
- PC_W, 6, width of CPU program counter / breakpoint address.
- CNT_W, 8, width of run-count operand.
- EXEC_W, 16, width of retired-instruction counter.
- TMO, 16, max cycles to wait for cpu_idle to fall after a step pulse, and for cpu_idle to be high before issuing.

Ports:
- clk_in  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  high only in IDLE state.
- cmd_op  in  2  00 STEP, 01 RUN_N, 10 RUN_BP, 11 reserved (accepted; completes immediately with reason COUNT, no step).
- cmd_count  in  CNT_W  instruction count for RUN_N (ignored otherwise).
- bp_addr  in  PC_W  breakpoint PC for RUN_BP, latched at accept.
- halt_req  in  1  request stop after the current instruction.
- cpu_idle  in  1  CPU idle flag.
- cpu_pc  in  PC_W  CPU program counter.
- cpu_step  out  1  one-cycle step pulse to CPU.
- cpu_en  out  1  CPU enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a command completes.
- halt_reason  out  2  00 COUNT, 01 BREAKPOINT, 10 ABORT, 11 TIMEOUT; valid from the done pulse until the next accept.
- exec_count  out  EXEC_W  instructions retired since reset.

Behaviour:
- Reset values: cmd_ready=1, cpu_step=0, cpu_en=1, busy=0, done=0, halt_reason=00, exec_count=0. Internal counters are cleared, the halt latch is cleared, and the state goes to IDLE.
- Reset mid-command aborts immediately. No done pulse is generated.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CHECK.
- IDLE
  - Accept occurs when cmd_valid & cmd_ready; the accepting edge latches op, count, and bp_addr. cpu_en is set to 1.
  - STEP loads remaining=1. RUN_N loads remaining=cmd_count.
  - RUN_N with count 0, or reserved op: next cycle done=1, reason COUNT, stay IDLE.
  - Otherwise go to ISSUE.
- ISSUE
  - If cpu_idle=1: drive cpu_step=1 for exactly this one cycle, clear the timer, then go to WAIT_BUSY.
  - Else hold cpu_step=0 and increment the timer. If the timer reaches TMO, go to fault.
- WAIT_BUSY
  - Wait for cpu_idle=0, then go to WAIT_DONE.
  - If TMO cycles elapse first, go to fault.
- WAIT_DONE
  - Wait for cpu_idle=1. There is no timeout here, because instruction length is bounded by the CPU.
  - On idle high: exec_count += 1 (wraps modulo 2^EXEC_W), remaining -= 1 for STEP/RUN_N, then go to CHECK.
- CHECK (one cycle). The first true condition wins:
  1. RUN_BP and cpu_pc == latched bp_addr: reason BREAKPOINT.
  2. STEP/RUN_N and remaining==0: reason COUNT.
  3. Halt latch set: reason ABORT.
  4. Else go back to ISSUE.
  - On completion: done=1 for one cycle and go to IDLE. cmd_ready rises in the same cycle as done.
- Breakpoint is evaluated only after an instruction retires. RUN_BP started with PC already at bp_addr executes at least one instruction. RUN_BP with no breakpoint hit runs until halt_req.
- halt_req
  - Sampled every non-IDLE cycle into a sticky latch. The latch clears on accept.
  - Ignored in IDLE.
  - Never truncates the step pulse or an instruction in flight.
- Fault (TIMEOUT): done=1, reason 11, cpu_en=0, go to IDLE. cpu_en stays 0 until the next accepted command. exec_count is not incremented.
- cpu_step is never high for more than one consecutive cycle, and never high outside ISSUE.
- Latency: a STEP accepted at edge N asserts cpu_step in cycle N+1 if the CPU is idle.

Test Plan:
- STEP with CPU idle, CPU model drops idle 2 cycles after step and raises it 3 cycles later -> exactly one step pulse, exec_count 0->1, done with reason 00, cmd_ready high in the done cycle.
- RUN_N count=5 against the program at 0x00 -> 5 step pulses, each one issued only after idle is seen high, exec_count=5, reason 00. Count=0 -> done next cycle, no step.
- RUN_BP bp_addr=0x03 from PC=0x00 -> stops with cpu_pc=0x03, reason 01, exec_count=3. Repeat from PC=0x03 with bp 0x03 -> keeps running, does not halt immediately.
- RUN_N count=200 with halt_req pulsed during the 2nd instruction -> the 2nd instruction completes, no 3rd step, reason 10, exec_count=2.
- CPU model never drops idle after a step -> after TMO=16 cycles done with reason 11, cpu_en=0, exec_count unchanged. The next STEP accept restores cpu_en=1.
- Reset asserted during WAIT_DONE of RUN_N -> next cycle: IDLE, cpu_step=0, busy=0, exec_count=0, no done pulse.
